// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces active-low keys into level, press, release and repeat outputs.
// Auto-repeat is built only when KEY_REPEAT_EN is defined; otherwise key_repeat is tied low.
module key_debounce #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int KEY_NUM         = 4,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_repeat
);
    localparam int TICKS_PER_MS = CLK_FREQ_HZ / 1000;
    localparam logic [31:0] DB_CYC = (TICKS_PER_MS * DEBOUNCE_MS < 1) ? 32'd1 : 32'(TICKS_PER_MS * DEBOUNCE_MS);
`ifdef KEY_REPEAT_EN
    localparam logic [31:0] RD_CYC = (TICKS_PER_MS * REPEAT_DELAY_MS < 1) ? 32'd1 : 32'(TICKS_PER_MS * REPEAT_DELAY_MS);
    localparam logic [31:0] RR_CYC = (TICKS_PER_MS * REPEAT_RATE_MS < 1) ? 32'd1 : 32'(TICKS_PER_MS * REPEAT_RATE_MS);
`endif
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
    logic [KEY_NUM-1:0] sync_q1, sync_q2;
    // Synchronizer resets to released so reset can never look like a press
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= ~key;
            sync_q2 <= sync_q1;
        end
    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        state_t      state, state_n;
        logic [31:0] cnt, cnt_n, cnt_inc;
        logic        s, press_n, release_n, level_q, press_q, release_q;
        assign s       = sync_q2[i];
        assign cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;
`ifdef KEY_REPEAT_EN
        logic rep_phase, rep_phase_n, repeat_n, repeat_q;
`endif
        always_comb begin
            state_n   = state;
            cnt_n     = cnt;
            press_n   = 1'b0;
            release_n = 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_n    = 1'b0;
            rep_phase_n = rep_phase;
`endif
            case (state)
                IDLE:
                    if (s) begin
                        state_n = PRESS_DB;
                        cnt_n   = 32'd1;
                    end
                PRESS_DB:
                    if (!s) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == DB_CYC) begin
                        state_n = HELD;
                        cnt_n   = '0;
                        press_n = 1'b1;
                    end else
                        cnt_n = cnt_inc;
                HELD:
                    if (!s) begin
                        state_n = REL_DB;
                        cnt_n   = 32'd1;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cnt_inc == (rep_phase ? RR_CYC : RD_CYC)) begin
                        cnt_n       = '0;
                        repeat_n    = 1'b1;
                        rep_phase_n = 1'b1;
                    end else
                        cnt_n = cnt_inc;
`endif
                REL_DB:
                    if (s) begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end else if (cnt == DB_CYC) begin
                        state_n   = IDLE;
                        cnt_n     = '0;
                        release_n = 1'b1;
                    end else
                        cnt_n = cnt_inc;
                default: state_n = IDLE;
            endcase
`ifdef KEY_REPEAT_EN
            // Any excursion out of HELD restarts the repeat timer with the long delay
            if (state_n != HELD) rep_phase_n = 1'b0;
`endif
        end
        always_ff @(posedge sys_clk or negedge sys_rst_n)
            if (!sys_rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_n;
                cnt       <= cnt_n;
                level_q   <= (state_n == HELD) || (state_n == REL_DB);
                press_q   <= press_n;
                release_q <= release_n;
            end
`ifdef KEY_REPEAT_EN
        always_ff @(posedge sys_clk or negedge sys_rst_n)
            if (!sys_rst_n) begin
                rep_phase <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                rep_phase <= rep_phase_n;
                repeat_q  <= repeat_n;
            end
        assign key_repeat[i] = repeat_q;
`endif
        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
    end
`ifndef KEY_REPEAT_EN
    assign key_repeat = '0;
`endif
endmodule
